// File: rtl/traffic_lights_ctrl.sv
// Fixed-time four-way intersection controller: Moore FSM with a per-state dwell counter.
// Optional pedestrian scramble phase (S6) is enabled by defining TLC_PED_SCRAMBLE_EN.
module traffic_lights_ctrl #(
    parameter int unsigned G_TIME   = 30,
    parameter int unsigned Y_TIME   = 5,
    parameter int unsigned AR_TIME  = 2,
    parameter int unsigned SCR_TIME = 10
) (
    input  logic       clk,
    input  logic       reset,
    output logic       T12R,
    output logic       T12Y,
    output logic       T12G,
    output logic       T34R,
    output logic       T34Y,
    output logic       T34G,
    output logic       T5R,
    output logic       T5G,
    output logic       T6R,
    output logic       T6G,
    output logic [2:0] state,
    output logic [5:0] counter
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6
    } state_e;

    // Dwell times are stored as terminal counts (D-1) so they fit the 6-bit counter at D=64.
    localparam logic [5:0] GLast   = 6'(G_TIME - 1);
    localparam logic [5:0] YLast   = 6'(Y_TIME - 1);
    localparam logic [5:0] ArLast  = 6'(AR_TIME - 1);
`ifdef TLC_PED_SCRAMBLE_EN
    localparam logic [5:0] ScrLast = 6'(SCR_TIME - 1);
`endif

    if (G_TIME < 1 || G_TIME > 64) begin : g_chk_g
        $error("G_TIME out of range 1..64");
    end
    if (Y_TIME < 1 || Y_TIME > 64) begin : g_chk_y
        $error("Y_TIME out of range 1..64");
    end
    if (AR_TIME < 1 || AR_TIME > 64) begin : g_chk_ar
        $error("AR_TIME out of range 1..64");
    end
    if (SCR_TIME < 1 || SCR_TIME > 64) begin : g_chk_scr
        $error("SCR_TIME out of range 1..64");
    end

    state_e     state_q, state_d, next_state;
    logic [5:0] counter_q, counter_d;
    logic [5:0] dwell_last;
    logic       legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S0;
            counter_q <= 6'd0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    always_comb begin
        dwell_last = GLast;
        next_state = S0;
        legal      = 1'b1;
        case (state_q)
            S0: begin
                dwell_last = GLast;
                next_state = S1;
            end
            S1: begin
                dwell_last = YLast;
                next_state = S2;
            end
            S2: begin
                dwell_last = ArLast;
                next_state = S3;
            end
            S3: begin
                dwell_last = GLast;
                next_state = S4;
            end
            S4: begin
                dwell_last = YLast;
                next_state = S5;
            end
            S5: begin
                dwell_last = ArLast;
`ifdef TLC_PED_SCRAMBLE_EN
                next_state = S6;
`else
                next_state = S0;
`endif
            end
`ifdef TLC_PED_SCRAMBLE_EN
            S6: begin
                dwell_last = ScrLast;
                next_state = S0;
            end
`endif
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q + 6'd1;
        // Illegal codes recover to S0 on the next edge regardless of the counter.
        if (!legal) begin
            state_d   = S0;
            counter_d = 6'd0;
        end else if (counter_q == dwell_last) begin
            state_d   = next_state;
            counter_d = 6'd0;
        end
    end

    always_comb begin
        T12R = 1'b1;
        T12Y = 1'b0;
        T12G = 1'b0;
        T34R = 1'b1;
        T34Y = 1'b0;
        T34G = 1'b0;
        T5R  = 1'b1;
        T5G  = 1'b0;
        T6R  = 1'b1;
        T6G  = 1'b0;
        case (state_q)
            S0: begin
                T12R = 1'b0;
                T12G = 1'b1;
                T6R  = 1'b0;
                T6G  = 1'b1;
            end
            S1: begin
                T12R = 1'b0;
                T12Y = 1'b1;
            end
            S3: begin
                T34R = 1'b0;
                T34G = 1'b1;
                T5R  = 1'b0;
                T5G  = 1'b1;
            end
            S4: begin
                T34R = 1'b0;
                T34Y = 1'b1;
            end
`ifdef TLC_PED_SCRAMBLE_EN
            S6: begin
                T5R = 1'b0;
                T5G = 1'b1;
                T6R = 1'b0;
                T6G = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign state   = state_q;
    assign counter = counter_q;

endmodule

// File: tb/tb_traffic_lights_ctrl.sv
// Directed self-checking bench for traffic_lights_ctrl in its default build (no scramble phase).
module tb_traffic_lights_ctrl;

    logic       clk;
    logic       reset;
    logic       T12R, T12Y, T12G, T34R, T34Y, T34G, T5R, T5G, T6R, T6G;
    logic [2:0] state;
    logic [5:0] counter;
    logic [9:0] lamps;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    traffic_lights_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .T12R    (T12R),
        .T12Y    (T12Y),
        .T12G    (T12G),
        .T34R    (T34R),
        .T34Y    (T34Y),
        .T34G    (T34G),
        .T5R     (T5R),
        .T5G     (T5G),
        .T6R     (T6R),
        .T6G     (T6G),
        .state   (state),
        .counter (counter)
    );

    assign lamps = {T12R, T12Y, T12G, T34R, T34Y, T34G, T5R, T5G, T6R, T6G};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected lamp pattern {T12RYG, T34RYG, T5RG, T6RG} for a state code.
    function automatic int lamp_of(input int s);
        case (s)
            0:       return 10'b001_100_10_01;
            1:       return 10'b010_100_10_10;
            3:       return 10'b100_001_01_10;
            4:       return 10'b100_010_10_10;
            default: return 10'b100_100_10_10;
        endcase
    endfunction

    // Position within the 74-cycle plan: boundaries at 30, 35, 37, 67, 72.
    task automatic expect_at(input int cyc, output int es, output int ec);
        int ph;
        ph = cyc % 74;
        if (ph < 30)      begin es = 0; ec = ph;      end
        else if (ph < 35) begin es = 1; ec = ph - 30; end
        else if (ph < 37) begin es = 2; ec = ph - 35; end
        else if (ph < 67) begin es = 3; ec = ph - 37; end
        else if (ph < 72) begin es = 4; ec = ph - 67; end
        else              begin es = 5; ec = ph - 72; end
    endtask

    task automatic check_cycle(input int cyc);
        int es, ec;
        expect_at(cyc, es, ec);
        chk($sformatf("state@%0d", cyc), int'(state), es);
        chk($sformatf("counter@%0d", cyc), int'(counter), ec);
        chk($sformatf("lamps@%0d", cyc), int'(lamps), lamp_of(es));
        chk($sformatf("onehot@%0d", cyc),
            int'($onehot({T12R, T12Y, T12G}) && $onehot({T34R, T34Y, T34G})
                 && $onehot({T5R, T5G}) && $onehot({T6R, T6G})), 1);
        chk($sformatf("conflict@%0d", cyc), int'(!T12R && !T34R), 0);
    endtask

    task automatic run(input int n);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            check_cycle(c);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_counter"}, int'(counter), 0);
        chk({tag, "_lamps"}, int'(lamps), 10'b001_100_10_01);
    endtask

    initial begin
        reset = 1'b1;
        #2;
        check_reset_state("rst_async");
        // Reset held across an edge keeps the counter pinned.
        @(posedge clk);
        #1;
        check_reset_state("rst_held");
        #2;
        reset = 1'b0;

        run(29);
        chk("c29_state", int'(state), 0);
        chk("c29_counter", int'(counter), 29);
        run(0);
        @(posedge clk);
        #1;
        chk("c30_state", int'(state), 1);
        chk("c30_counter", int'(counter), 0);
        chk("c30_T12Y", int'(T12Y), 1);
        chk("c30_T6R", int'(T6R), 1);

        for (int c = 31; c <= 49; c++) begin
            @(posedge clk);
            #1;
            check_cycle(c);
        end
        chk("midS3_state", int'(state), 3);
        chk("midS3_counter", int'(counter), 12);

        // Reset pulse between edges aborts the cross-road green immediately.
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("rst_midS3");
        #1;
        reset = 1'b0;

        // Fresh run: S3 must again last 30 cycles, wrap at 74, invariants for 200 cycles.
        run(200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
